histo_frame_sequencer: RTL and testbench
========================================

// Module: histo_frame_sequencer
// PURPOSE
//  Sequences the pixel-histogram RAM through capture, drain and readout for each frame.
//  Arms on a start request and enables accumulation (histo_rw=1) from frame_start to frame_end.
//  Then walks bins 0..NUM_BINS-1 in read mode and streams each count out over a valid/ready port.
//  Counts the pixels accepted during the frame and checks the sum of all bins against that count.
//  Sits between the sensor pixel path / U3V control logic and the histogram block.
// PARAMETERS
//  NUM_BINS   1024  bins read per frame; power of 2, 2..1024
//  BIN_W      10    bin address width = log2(NUM_BINS)
//  CNT_W      24    histogram count width
//  RD_LAT     2     cycles from histo_bin change to valid histo_data, 1..7
//  DRAIN_CYC  4     cycles histo_rw stays 1 after frame_end so in-flight increments land, 1..15
// PORTS
//  clk          in   1      single clock; the histogram runs on this same clock
//  rst          in   1      synchronous, active-low reset
//  start        in   1      1-cycle arm request; honoured only in IDLE
//  continuous   in   1      1: re-arm automatically after DONE; sampled in DONE
//  abort        in   1      return to IDLE next cycle; no stream output
//  frame_start  in   1      1-cycle pulse, first pixel of frame
//  frame_end    in   1      1-cycle pulse after last pixel (image_done)
//  pixel_valid  in   1      pixel accepted into histogram this cycle
//  histo_rw     out  1      1 = write/accumulate, 0 = read
//  histo_bin    out  BIN_W  read address to histogram
//  histo_data   in   CNT_W  bin count returned by histogram
//  out_valid    out  1      out_data/out_bin/out_last valid
//  out_ready    in   1      sink accepts the beat when out_valid & out_ready
//  out_data     out  CNT_W  bin count
//  out_bin      out  BIN_W  bin index of out_data
//  out_last     out  1      high with bin NUM_BINS-1
//  busy         out  1      state != IDLE
//  done         out  1      1-cycle pulse when the frame readout completes
//  frame_cnt    out  16     completed frames; wraps 0xFFFF -> 0
//  sum_err      out  1      sticky; set in DONE if bin sum != pixel count; cleared by start
// BEHAVIOUR
//  Reset (rst=0 at a clk edge), all outputs:
//   state=IDLE, histo_rw=0, histo_bin=0, out_*=0, busy=0, done=0, frame_cnt=0, sum_err=0.
//  Reset mid-operation is identical; any beat in flight is dropped.
//  FSM transitions:
//   IDLE  -> ARM on start; clears sum_err, pix_cnt and bin_sum.
//   ARM   -> ACCUM on frame_start; histo_rw=1 from the next cycle.
//   ACCUM: pix_cnt += pixel_valid (32-bit, saturates at 2^32-1).
//          Includes pixel_valid in the frame_start cycle and the frame_end cycle.
//   ACCUM -> DRAIN on frame_end; histo_rw stays 1 for exactly DRAIN_CYC cycles.
//            frame_start while in ACCUM is ignored.
//   DRAIN -> RADDR; histo_rw=0, bin index b=0.
//   RADDR: drive histo_bin=b, then RWAIT for RD_LAT cycles.
//   RWAIT: on the last wait cycle, latch histo_data into out_data, set out_bin=b,
//          out_last=(b==NUM_BINS-1), assert out_valid; bin_sum += histo_data (32-bit, saturating).
//   PRESENT: hold all out_* stable while out_valid & !out_ready.
//     On handshake: if b<NUM_BINS-1, b++ and go to RADDR with out_valid=0; else go to DONE.
//     Throughput is one bin per RD_LAT+2 cycles at full ready.
//   DONE: 1 cycle; done=1, frame_cnt++, sum_err|=(bin_sum!=pix_cnt).
//     Next state is ARM if continuous=1 (counters cleared), else IDLE.
//  Boundaries and special cases:
//   frame_end in ARM (no frame_start seen) is ignored.
//   start outside IDLE is ignored.
//   abort has priority over every other transition except reset:
//     next cycle state=IDLE, histo_rw=0, out_valid=0; frame_cnt unchanged; no done pulse.
//   abort and start in the same cycle in IDLE: abort wins, stay IDLE.
//   frame_cnt wraps silently.
// TESTING
//  T1 start; frame_start; 100 pixel_valid on bins 5 and 7 (60/40); frame_end; out_ready=1
//     -> 1024 beats, bin5=60, bin7=40, rest 0, out_last on beat 1023, done=1, sum_err=0, frame_cnt=1.
//  T2 as T1 with out_ready toggling 1-of-3 cycles
//     -> out_data/out_bin held stable while stalled, no beat lost or repeated.
//  T3 histogram model drops one increment -> sum_err=1 after DONE; next start clears it.
//  T4 abort during ACCUM and again at bin 300 of readout
//     -> IDLE next cycle, out_valid=0, no done pulse, frame_cnt unchanged.
//  T5 continuous=1 over 3 frames -> frame_cnt=3, ARM re-entered without start, histo_rw=0 between frames.
//  T6 rst=0 at bin 512 with out_valid held -> all outputs at reset values on the next cycle;
//     frame_end in ARM ignored.

Source files
------------

// File: rtl/histo_frame_sequencer.sv
// Frame sequencer for the pixel histogram RAM: arms, accumulates one frame, drains in-flight
// increments, then streams every bin over valid/ready while checking the bin sum against the pixel count.
module histo_frame_sequencer #(
    parameter int unsigned NUM_BINS  = 1024,
    parameter int unsigned BIN_W     = 10,
    parameter int unsigned CNT_W     = 24,
    parameter int unsigned RD_LAT    = 2,
    parameter int unsigned DRAIN_CYC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              continuous,
    input  logic              abort,
    input  logic              frame_start,
    input  logic              frame_end,
    input  logic              pixel_valid,
    output logic              histo_rw,
    output logic [BIN_W-1:0]  histo_bin,
    input  logic [CNT_W-1:0]  histo_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  out_data,
    output logic [BIN_W-1:0]  out_bin,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic [15:0]       frame_cnt,
    output logic              sum_err
);

    localparam int unsigned SUM_W  = 32;
    localparam int unsigned TMR_W  = 4;
    localparam int unsigned FCNT_W = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        ACCUM   = 3'd2,
        DRAIN   = 3'd3,
        RADDR   = 3'd4,
        RWAIT   = 3'd5,
        PRESENT = 3'd6,
        DONE    = 3'd7
    } state_t;

    state_t              state, state_nxt;
    logic [TMR_W-1:0]    tmr, tmr_nxt;
    logic [SUM_W-1:0]    pix_cnt, pix_cnt_nxt;
    logic [SUM_W-1:0]    bin_sum, bin_sum_nxt;
    logic                histo_rw_nxt;
    logic [BIN_W-1:0]    histo_bin_nxt;
    logic                out_valid_nxt;
    logic [CNT_W-1:0]    out_data_nxt;
    logic [BIN_W-1:0]    out_bin_nxt;
    logic                out_last_nxt;
    logic                busy_nxt;
    logic                done_nxt;
    logic [FCNT_W-1:0]   frame_cnt_nxt;
    logic                sum_err_nxt;

    // Saturating arithmetic shared by the FSM
    logic                last_bin;
    logic [SUM_W-1:0]    pix_cnt_inc;
    logic [SUM_W:0]      sum_ext;
    logic [SUM_W-1:0]    bin_sum_add;

    assign last_bin    = (histo_bin == BIN_W'(NUM_BINS - 1));
    assign pix_cnt_inc = (pixel_valid && (pix_cnt != '1)) ? pix_cnt + SUM_W'(1) : pix_cnt;
    assign sum_ext     = {1'b0, bin_sum} + (SUM_W + 1)'(histo_data);
    assign bin_sum_add = sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];

    // Next-state and next-output logic; histo_bin doubles as the readout bin index
    always_comb begin
        state_nxt     = state;
        tmr_nxt       = tmr;
        pix_cnt_nxt   = pix_cnt;
        bin_sum_nxt   = bin_sum;
        histo_rw_nxt  = histo_rw;
        histo_bin_nxt = histo_bin;
        out_valid_nxt = out_valid;
        out_data_nxt  = out_data;
        out_bin_nxt   = out_bin;
        out_last_nxt  = out_last;
        done_nxt      = 1'b0;
        frame_cnt_nxt = frame_cnt;
        sum_err_nxt   = sum_err;

        if (abort) begin
            state_nxt     = IDLE;
            histo_rw_nxt  = 1'b0;
            out_valid_nxt = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_nxt   = ARM;
                        sum_err_nxt = 1'b0;
                        pix_cnt_nxt = '0;
                        bin_sum_nxt = '0;
                    end
                end
                ARM: begin
                    if (frame_start) begin
                        state_nxt    = ACCUM;
                        histo_rw_nxt = 1'b1;
                        pix_cnt_nxt  = pix_cnt_inc;
                    end
                end
                ACCUM: begin
                    pix_cnt_nxt = pix_cnt_inc;
                    if (frame_end) begin
                        state_nxt = DRAIN;
                        tmr_nxt   = TMR_W'(DRAIN_CYC - 1);
                    end
                end
                DRAIN: begin
                    if (tmr == '0) begin
                        state_nxt     = RADDR;
                        histo_rw_nxt  = 1'b0;
                        histo_bin_nxt = '0;
                    end else begin
                        tmr_nxt = tmr - TMR_W'(1);
                    end
                end
                RADDR: begin
                    state_nxt = RWAIT;
                    tmr_nxt   = TMR_W'(RD_LAT - 1);
                end
                RWAIT: begin
                    if (tmr == '0) begin
                        state_nxt     = PRESENT;
                        out_valid_nxt = 1'b1;
                        out_data_nxt  = histo_data;
                        out_bin_nxt   = histo_bin;
                        out_last_nxt  = last_bin;
                        bin_sum_nxt   = bin_sum_add;
                    end else begin
                        tmr_nxt = tmr - TMR_W'(1);
                    end
                end
                PRESENT: begin
                    if (out_ready) begin
                        out_valid_nxt = 1'b0;
                        if (last_bin) begin
                            state_nxt     = DONE;
                            done_nxt      = 1'b1;
                            frame_cnt_nxt = frame_cnt + FCNT_W'(1);
                            sum_err_nxt   = sum_err | (bin_sum != pix_cnt);
                        end else begin
                            state_nxt     = RADDR;
                            histo_bin_nxt = histo_bin + BIN_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (continuous) begin
                        state_nxt   = ARM;
                        pix_cnt_nxt = '0;
                        bin_sum_nxt = '0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end

        busy_nxt = (state_nxt != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            tmr       <= '0;
            pix_cnt   <= '0;
            bin_sum   <= '0;
            histo_rw  <= 1'b0;
            histo_bin <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_bin   <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            frame_cnt <= '0;
            sum_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            tmr       <= tmr_nxt;
            pix_cnt   <= pix_cnt_nxt;
            bin_sum   <= bin_sum_nxt;
            histo_rw  <= histo_rw_nxt;
            histo_bin <= histo_bin_nxt;
            out_valid <= out_valid_nxt;
            out_data  <= out_data_nxt;
            out_bin   <= out_bin_nxt;
            out_last  <= out_last_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            frame_cnt <= frame_cnt_nxt;
            sum_err   <= sum_err_nxt;
        end
    end

endmodule

// File: tb/tb_histo_frame_sequencer.sv
// Directed bench for histo_frame_sequencer with a small latency-accurate histogram RAM model
// and a stream monitor that checks bin order, bin contents, out_last and stall stability.
module tb_histo_frame_sequencer;

    localparam int unsigned NUM_BINS  = 1024;
    localparam int unsigned BIN_W     = 10;
    localparam int unsigned CNT_W     = 24;
    localparam int unsigned RD_LAT    = 2;
    localparam int unsigned DRAIN_CYC = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              continuous = 1'b0;
    logic              abort = 1'b0;
    logic              frame_start = 1'b0;
    logic              frame_end = 1'b0;
    logic              pixel_valid = 1'b0;
    logic              histo_rw;
    logic [BIN_W-1:0]  histo_bin;
    logic [CNT_W-1:0]  histo_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [CNT_W-1:0]  out_data;
    logic [BIN_W-1:0]  out_bin;
    logic              out_last;
    logic              busy;
    logic              done;
    logic [15:0]       frame_cnt;
    logic              sum_err;

    always #5 clk = ~clk;

    histo_frame_sequencer #(
        .NUM_BINS (NUM_BINS),
        .BIN_W    (BIN_W),
        .CNT_W    (CNT_W),
        .RD_LAT   (RD_LAT),
        .DRAIN_CYC(DRAIN_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .continuous (continuous),
        .abort      (abort),
        .frame_start(frame_start),
        .frame_end  (frame_end),
        .pixel_valid(pixel_valid),
        .histo_rw   (histo_rw),
        .histo_bin  (histo_bin),
        .histo_data (histo_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_bin    (out_bin),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done),
        .frame_cnt  (frame_cnt),
        .sum_err    (sum_err)
    );

    // Histogram RAM model: increments land two cycles after the pixel, reads take RD_LAT cycles
    logic [CNT_W-1:0] mem [NUM_BINS];
    logic [BIN_W-1:0] pix_bin = '0;
    logic [BIN_W-1:0] p1_b = '0, p2_b = '0;
    logic             p1_v = 1'b0, p2_v = 1'b0;
    logic [CNT_W-1:0] rd1 = '0, rd2 = '0;
    logic             hclr = 1'b0, drop_req = 1'b0, dropped = 1'b0;

    always @(posedge clk) begin
        p1_v <= pixel_valid;
        p1_b <= pix_bin;
        p2_v <= p1_v;
        p2_b <= p1_b;
        rd1  <= mem[histo_bin];
        rd2  <= rd1;
        if (hclr) begin
            for (int i = 0; i < NUM_BINS; i++) mem[i] <= '0;
            dropped <= 1'b0;
        end else if (p2_v && histo_rw) begin
            if (drop_req && !dropped) dropped <= 1'b1;
            else mem[p2_b] <= CNT_W'(mem[p2_b] + 1'b1);
        end
    end
    assign histo_data = rd2;

    // Sink readiness: always ready, or ready one cycle in three
    logic ready_en = 1'b0, stall_mode = 1'b0;
    int   rdy_ph = 0;
    always begin
        @(posedge clk);
        #2;
        rdy_ph    = (rdy_ph == 2) ? 0 : rdy_ph + 1;
        out_ready = ready_en && (!stall_mode || rdy_ph == 0);
    end

    // Stream monitor
    logic [CNT_W-1:0] exp_h [NUM_BINS];
    int done_cnt = 0, beat_tot = 0, beat_n = 0;
    int bin_err = 0, data_err = 0, last_err = 0, stall_err = 0;
    logic             prev_stall = 1'b0, p_last = 1'b0;
    logic [CNT_W-1:0] p_data = '0;
    logic [BIN_W-1:0] p_bin = '0;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (prev_stall && !(out_valid === 1'b1 && out_data === p_data &&
                            out_bin === p_bin && out_last === p_last)) stall_err++;
        prev_stall = rst && !abort && (out_valid === 1'b1) && !out_ready;
        p_data = out_data;
        p_bin  = out_bin;
        p_last = out_last;
        if (busy !== 1'b1) begin
            beat_n = 0;
        end else if (out_valid === 1'b1 && out_ready) begin
            if (out_bin !== BIN_W'(beat_n)) bin_err++;
            if (out_data !== exp_h[beat_n]) data_err++;
            if (out_last !== (beat_n == NUM_BINS - 1)) last_err++;
            beat_tot++;
            beat_n = (beat_n == NUM_BINS - 1) ? 0 : beat_n + 1;
        end
    end

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic clear_histo();
        hclr = 1'b1;
        tick();
        hclr = 1'b0;
    endtask

    task automatic set_exp(input int b5, input int b7);
        for (int i = 0; i < NUM_BINS; i++) exp_h[i] = '0;
        exp_h[5] = CNT_W'(b5);
        exp_h[7] = CNT_W'(b7);
    endtask

    // 100 pixels (60 on bin 5, 40 on bin 7), pixels on the frame_start and frame_end cycles too
    task automatic run_frame();
        for (int i = 0; i < 100; i++) begin
            frame_start = (i == 0);
            frame_end   = (i == 99);
            pixel_valid = 1'b1;
            pix_bin     = (i % 5 < 3) ? BIN_W'(5) : BIN_W'(7);
            tick();
            frame_start = 1'b0;
            frame_end   = 1'b0;
            pixel_valid = 1'b0;
            if (i % 10 == 9) tick();
        end
    endtask

    task automatic wait_done(input string tag, input int budget, output int n);
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_done_seen"}, done, 1);
    endtask

    task automatic wait_bin(input string tag, input int bin);
        int n = 0;
        while (!(out_valid === 1'b1 && out_bin === BIN_W'(bin)) && n < 20000) begin
            tick();
            n++;
        end
        chk({tag, "_reached"}, out_valid, 1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_histo_rw"}, histo_rw, 0);
        chk({tag, "_histo_bin"}, histo_bin, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_bin"}, out_bin, 0);
        chk({tag, "_out_last"}, out_last, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_frame_cnt"}, frame_cnt, 0);
        chk({tag, "_sum_err"}, sum_err, 0);
    endtask

    initial begin
        int b0, d0, n;

        do_reset();
        clear_histo();
        chk_reset_vals("rst");

        // T1: full frame at full ready
        set_exp(60, 40);
        ready_en = 1'b1;
        b0 = beat_tot;
        d0 = done_cnt;
        pulse_start();
        chk("t1_arm_busy", busy, 1);
        chk("t1_arm_rw", histo_rw, 0);
        run_frame();
        chk("t1_drain_rw", histo_rw, 1);
        tick();
        tick();
        chk("t1_drain_last", histo_rw, 1);
        tick();
        chk("t1_drain_off", histo_rw, 0);
        wait_done("t1", 20000, n);
        chk("t1_cycles", n, (RD_LAT + 2) * NUM_BINS);
        chk("t1_frame_cnt", frame_cnt, 1);
        chk("t1_sum_err", sum_err, 0);
        tick();
        tick();
        chk("t1_done_pulses", done_cnt - d0, 1);
        chk("t1_idle", busy, 0);
        chk("t1_beats", beat_tot - b0, NUM_BINS);
        chk("t1_bin_err", bin_err, 0);
        chk("t1_data_err", data_err, 0);
        chk("t1_last_err", last_err, 0);

        // T2: sink ready one cycle in three; start mid-readout must be ignored
        clear_histo();
        stall_mode = 1'b1;
        b0 = beat_tot;
        pulse_start();
        run_frame();
        repeat (200) tick();
        pulse_start();
        wait_done("t2", 30000, n);
        chk("t2_frame_cnt", frame_cnt, 2);
        chk("t2_sum_err", sum_err, 0);
        tick();
        tick();
        chk("t2_beats", beat_tot - b0, NUM_BINS);
        chk("t2_bin_err", bin_err, 0);
        chk("t2_data_err", data_err, 0);
        chk("t2_stall_err", stall_err, 0);
        stall_mode = 1'b0;

        // T3: histogram drops the first increment
        clear_histo();
        drop_req = 1'b1;
        set_exp(59, 40);
        pulse_start();
        run_frame();
        wait_done("t3", 20000, n);
        chk("t3_sum_err", sum_err, 1);
        chk("t3_frame_cnt", frame_cnt, 3);
        tick();
        tick();
        chk("t3_sticky", sum_err, 1);
        chk("t3_data_err", data_err, 0);
        drop_req = 1'b0;
        pulse_start();
        chk("t3_cleared", sum_err, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t3_abort_arm", busy, 0);

        // T4: abort in ACCUM and mid-readout; abort beats start in IDLE
        set_exp(60, 40);
        d0 = done_cnt;
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        chk("t4_abort_start", busy, 0);
        clear_histo();
        pulse_start();
        frame_start = 1'b1;
        pixel_valid = 1'b1;
        tick();
        frame_start = 1'b0;
        pixel_valid = 1'b0;
        tick();
        chk("t4_accum_rw", histo_rw, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t4_accum_busy", busy, 0);
        chk("t4_accum_rw_off", histo_rw, 0);
        clear_histo();
        pulse_start();
        run_frame();
        wait_bin("t4_bin300", 300);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t4_rd_valid", out_valid, 0);
        chk("t4_rd_busy", busy, 0);
        repeat (3) tick();
        chk("t4_no_done", done_cnt - d0, 0);
        chk("t4_frame_cnt", frame_cnt, 3);
        chk("t4_data_err", data_err, 0);

        // T5: three frames in continuous mode
        do_reset();
        clear_histo();
        d0 = done_cnt;
        continuous = 1'b1;
        pulse_start();
        for (int f = 0; f < 3; f++) begin
            run_frame();
            wait_done("t5", 20000, n);
            if (f == 2) continuous = 1'b0;
            chk("t5_frame_cnt", frame_cnt, f + 1);
            tick();
            chk("t5_between_rw", histo_rw, 0);
            chk("t5_rearm", busy, (f < 2) ? 1 : 0);
            clear_histo();
        end
        chk("t5_done_pulses", done_cnt - d0, 3);
        chk("t5_sum_err", sum_err, 0);
        chk("t5_data_err", data_err, 0);

        // T6: reset while a beat is held, then frame_end in ARM
        pulse_start();
        run_frame();
        wait_bin("t6_bin512", 512);
        ready_en = 1'b0;
        tick();
        tick();
        chk("t6_held_valid", out_valid, 1);
        chk("t6_held_bin", out_bin, 512);
        rst = 1'b0;
        tick();
        chk_reset_vals("t6_rst");
        rst = 1'b1;
        ready_en = 1'b1;
        tick();
        clear_histo();
        pulse_start();
        frame_end = 1'b1;
        pixel_valid = 1'b1;
        tick();
        frame_end = 1'b0;
        pixel_valid = 1'b0;
        repeat (4) tick();
        chk("t6_arm_busy", busy, 1);
        chk("t6_arm_rw", histo_rw, 0);
        run_frame();
        wait_done("t6", 20000, n);
        chk("t6_sum_err", sum_err, 0);
        chk("t6_frame_cnt", frame_cnt, 1);
        tick();
        tick();
        chk("t6_data_err", data_err, 0);
        chk("t6_stall_err", stall_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
